// File: rtl/dmem_lsu.sv
// Data memory with a load/store front end: request/grant/response handshake and configurable read latency.
// Optional macro DMEM_MISALIGN_ERR_EN turns misaligned half/word accesses into errors instead of force-aligning them.
`timescale 1ns/1ps
module dmem_lsu #(
  parameter logic [31:0] BASE_ADDR    = 32'h8800_0000,
  parameter int          DEPTH_WORDS  = 256,
  parameter int          READ_LATENCY = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);
  // Handshake: a request is taken at any rising edge with req_i & gnt_o; the requester holds
  // req_i and its operands until then. Every taken request gets exactly one rvalid_o pulse.
  localparam int          AW      = $clog2(DEPTH_WORDS);
  localparam logic [29:0] DEPTH_W = 30'(DEPTH_WORDS);

  typedef enum logic {IDLE, WAIT} state_t;
  state_t state;

  logic [31:0] mem [DEPTH_WORDS];
  logic [30:0] off_w;
  logic        in_range, misalign, bad_align, acc_err, do_write;
  logic [AW-1:0] idx;
  logic [1:0]  lane;
  logic [3:0]  be;
  logic [31:0] lane_wdata, rd_word, shifted, load_data, resp_data;
  logic [2:0]  cnt;
  logic [31:0] pend_data;
  logic        pend_err;

  // Word offset with a borrow bit so addresses below the base fall out of range.
  assign off_w    = {1'b0, addr_i[31:2]} - {1'b0, BASE_ADDR[31:2]};
  assign in_range = ~off_w[30] && (off_w[29:0] < DEPTH_W);
  assign idx      = off_w[AW-1:0];
  assign misalign = (size_i == 2'b01 && addr_i[0]) || (size_i == 2'b10 && addr_i[1:0] != 2'b00);
`ifdef DMEM_MISALIGN_ERR_EN
  assign bad_align = misalign;
`else
  assign bad_align = 1'b0;
`endif
  assign acc_err = ~in_range || (size_i == 2'b11) || bad_align;

  always_comb begin
    lane       = 2'b00;
    be         = 4'b0000;
    lane_wdata = wdata_i;
    case (size_i)
      2'b00: begin
        lane       = addr_i[1:0];
        be         = 4'b0001 << addr_i[1:0];
        lane_wdata = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        lane       = {addr_i[1], 1'b0};
        be         = 4'b0011 << {addr_i[1], 1'b0};
        lane_wdata = {2{wdata_i[15:0]}};
      end
      2'b10: be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  assign do_write = req_i & gnt_o & ~rst_i & we_i & ~acc_err;

  // Storage is deliberately left unreset.
  always_ff @(posedge clk_i) begin
    if (do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= lane_wdata[8*b +: 8];
      end
    end
  end

  assign rd_word = mem[idx];
  assign shifted = rd_word >> {lane, 3'b000};

  always_comb begin
    load_data = rd_word;
    case (size_i)
      2'b00: load_data = unsigned_i ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      2'b01: load_data = unsigned_i ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: load_data = rd_word;
    endcase
  end

  assign resp_data = (we_i || acc_err) ? 32'b0 : load_data;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      gnt_o     <= 1'b1;
      rvalid_o  <= 1'b0;
      rdata_o   <= 32'b0;
      err_o     <= 1'b0;
      cnt       <= 3'd0;
      pend_data <= 32'b0;
      pend_err  <= 1'b0;
    end else begin
      rvalid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (req_i && gnt_o) begin
            if (we_i || READ_LATENCY == 1) begin
              rvalid_o <= 1'b1;
              rdata_o  <= resp_data;
              err_o    <= acc_err;
            end else begin
              state     <= WAIT;
              gnt_o     <= 1'b0;
              cnt       <= 3'(READ_LATENCY - 1);
              pend_data <= resp_data;
              pend_err  <= acc_err;
            end
          end
        end
        WAIT: begin
          if (cnt == 3'd1) begin
            state    <= IDLE;
            gnt_o    <= 1'b1;
            rvalid_o <= 1'b1;
            rdata_o  <= pend_data;
            err_o    <= pend_err;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: two instances (read latency 1 and 3) checked against a byte-array reference model.
`timescale 1ns/1ps
module tb_dmem_lsu;
  localparam logic [31:0] BASE  = 32'h8800_0000;
  localparam int          DEPTH = 256;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req [2];
  logic        we [2];
  logic        uns [2];
  logic [1:0]  size [2];
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic        gnt [2];
  logic        rvalid [2];
  logic        err [2];
  logic [31:0] rdata [2];

  dmem_lsu #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .READ_LATENCY(1)) u_dut_l1 (
    .clk_i(clk), .rst_i(rst), .req_i(req[0]), .we_i(we[0]), .size_i(size[0]),
    .unsigned_i(uns[0]), .addr_i(addr[0]), .wdata_i(wdata[0]), .gnt_o(gnt[0]),
    .rvalid_o(rvalid[0]), .rdata_o(rdata[0]), .err_o(err[0]));

  dmem_lsu #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .READ_LATENCY(3)) u_dut_l3 (
    .clk_i(clk), .rst_i(rst), .req_i(req[1]), .we_i(we[1]), .size_i(size[1]),
    .unsigned_i(uns[1]), .addr_i(addr[1]), .wdata_i(wdata[1]), .gnt_o(gnt[1]),
    .rvalid_o(rvalid[1]), .rdata_o(rdata[1]), .err_o(err[1]));

  // scoreboard
  int vectors = 0;
  int miscompares = 0;
  logic [7:0]  ref_mem [2][DEPTH*4];
  logic [31:0] exp_q [$];

  function automatic int lat_of(input int p);
    return (p == 0) ? 1 : 3;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: memory as a flat byte array, access judged by its first and last byte.
  function automatic void model(input int p, input logic w, input logic [1:0] sz, input logic u,
                                input logic [31:0] a, input logic [31:0] wd,
                                output logic [31:0] d, output logic e);
    int n;
    longint off;
    logic [31:0] aa;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
`ifdef DMEM_MISALIGN_ERR_EN
    aa = a;
    e  = (a % n) != 0;
`else
    aa = a - (a % n);
    e  = 1'b0;
`endif
    off = longint'(aa) - longint'(BASE);
    e = e || (sz == 2'd3) || (off < 0) || (off + n > DEPTH * 4);
    d = 32'b0;
    if (!e) begin
      if (w) begin
        for (int i = 0; i < n; i++) ref_mem[p][int'(off) + i] = wd[8*i +: 8];
      end else begin
        for (int i = 0; i < n; i++) d[8*i +: 8] = ref_mem[p][int'(off) + i];
        if (!u && n < 4 && d[8*n-1]) d = d | ~((32'd1 << (8*n)) - 32'd1);
      end
    end
  endfunction

  // driver: one access, waits for grant and response with bounded budgets
  task automatic access(input int p, input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd, input string tag,
                        output logic [31:0] got, output logic got_err);
    logic [31:0] ed;
    logic ee;
    int lat;
    int wt;
    model(p, w, sz, u, a, wd, ed, ee);
    exp_q.push_back(ed);
    exp_q.push_back({31'b0, ee});
    @(negedge clk);
    req[p] = 1'b1; we[p] = w; size[p] = sz; uns[p] = u; addr[p] = a; wdata[p] = wd;
    wt = 0;
    while (!gnt[p] && wt < 20) begin
      @(negedge clk);
      wt++;
    end
    if (!gnt[p]) check({tag, " grant"}, {31'b0, gnt[p]}, 32'd1);
    @(posedge clk);
    #1;
    req[p] = 1'b0;
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      if (rvalid[p]) begin
        lat = k;
        break;
      end
      @(posedge clk);
      #1;
    end
    got = rdata[p];
    got_err = err[p];
    check({tag, " latency"}, 32'(lat), w ? 32'd1 : 32'(lat_of(p)));
    check({tag, " data"}, got, exp_q.pop_front());
    check({tag, " err"}, {31'b0, got_err}, exp_q.pop_front());
    @(posedge clk);
    #1;
    check({tag, " pulse"}, {31'b0, rvalid[p]}, 32'd0);
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return BASE + 32'h3F0 + $urandom_range(0, 31);
    if (r == 1) return BASE - $urandom_range(1, 8);
    return BASE + $urandom_range(0, 63);
  endfunction

  function automatic logic [1:0] rand_size();
    return ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
  endfunction

  logic [31:0] g;
  logic        e;
  int          rv_seen;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    for (int p = 0; p < 2; p++) begin
      req[p] = 1'b0; we[p] = 1'b0; uns[p] = 1'b0; size[p] = 2'd0; addr[p] = 32'b0; wdata[p] = 32'b0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      check("reset gnt", {31'b0, gnt[p]}, 32'd1);
      check("reset rvalid", {31'b0, rvalid[p]}, 32'd0);
      check("reset rdata", rdata[p], 32'd0);
      check("reset err", {31'b0, err[p]}, 32'd0);
    end
    rst = 1'b0;

    for (int p = 0; p < 2; p++) begin
      access(p, 1, 2'd2, 0, BASE, 32'hDEAD_BEEF, "tp1 sw", g, e);
      access(p, 0, 2'd2, 0, BASE, 32'h0, "tp1 lw", g, e);
      check("tp1 lw value", g, 32'hDEAD_BEEF);
      access(p, 1, 2'd2, 0, BASE + 4, 32'h0, "tp2 sw", g, e);
      access(p, 1, 2'd0, 0, BASE + 5, 32'h80, "tp2 sb", g, e);
      access(p, 0, 2'd0, 0, BASE + 5, 32'h0, "tp2 lb", g, e);
      check("tp2 lb value", g, 32'hFFFF_FF80);
      access(p, 0, 2'd0, 1, BASE + 5, 32'h0, "tp2 lbu", g, e);
      check("tp2 lbu value", g, 32'h0000_0080);
      access(p, 0, 2'd2, 0, BASE + 4, 32'h0, "tp2 lw", g, e);
      check("tp2 lw value", g, 32'h0000_8000);
      access(p, 1, 2'd1, 0, BASE + 6, 32'hF234, "tp3 sh", g, e);
      access(p, 0, 2'd1, 1, BASE + 6, 32'h0, "tp3 lhu", g, e);
      check("tp3 lhu value", g, 32'h0000_F234);
      access(p, 0, 2'd1, 0, BASE + 6, 32'h0, "tp3 lh", g, e);
      check("tp3 lh value", g, 32'hFFFF_F234);
      access(p, 0, 2'd2, 0, BASE + 4, 32'h0, "tp3 lw", g, e);
      check("tp3 lw value", g, 32'hF234_8000);
      access(p, 0, 2'd2, 0, BASE + 32'h400, 32'h0, "tp4 lw top", g, e);
      check("tp4 lw top err", {31'b0, e}, 32'd1);
      access(p, 1, 2'd2, 0, BASE - 4, 32'h1, "tp4 sw low", g, e);
      check("tp4 sw low err", {31'b0, e}, 32'd1);
      access(p, 0, 2'd2, 0, BASE, 32'h0, "tp4 lw intact", g, e);
      check("tp4 lw intact value", g, 32'hDEAD_BEEF);
      access(p, 0, 2'd3, 0, BASE, 32'h0, "tp4 size11", g, e);
      check("tp4 size11 err", {31'b0, e}, 32'd1);
      access(p, 0, 2'd2, 0, BASE + 2, 32'h0, "tp5 lw mis", g, e);
`ifdef DMEM_MISALIGN_ERR_EN
      check("tp5 mis err", {31'b0, e}, 32'd1);
      check("tp5 mis value", g, 32'h0);
`else
      check("tp5 mis err", {31'b0, e}, 32'd0);
      check("tp5 mis value", g, 32'hDEAD_BEEF);
`endif
    end

    // store coinciding with reset assertion must not land
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; size[0] = 2'd2; addr[0] = BASE; wdata[0] = 32'h1234_5678;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req[0] = 1'b0;
    rst = 1'b0;
    access(0, 0, 2'd2, 0, BASE, 32'h0, "reset store", g, e);
    check("reset store value", g, 32'hDEAD_BEEF);

    for (int p = 0; p < 2; p++) begin
      for (int w = 0; w < 16; w++) access(p, 1, 2'd2, 0, BASE + 4*w, $urandom, "preload", g, e);
      for (int w = 252; w < 256; w++) access(p, 1, 2'd2, 0, BASE + 4*w, $urandom, "preload", g, e);
      for (int i = 0; i < 120; i++)
        access(p, 1'($urandom_range(0, 1)), rand_size(), 1'($urandom_range(0, 1)), rand_addr(),
               $urandom, "random", g, e);
    end

    // reset one cycle into a latency-3 read
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b0; size[1] = 2'd2; addr[1] = BASE;
    @(posedge clk);
    #1;
    req[1] = 1'b0;
    rv_seen = 0;
    @(posedge clk);
    #1;
    rv_seen += int'(rvalid[1]);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("abort gnt after reset", {31'b0, gnt[1]}, 32'd1);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      rv_seen += int'(rvalid[1]);
    end
    check("abort no rvalid", 32'(rv_seen), 32'd0);
    access(1, 0, 2'd2, 0, BASE + 8, 32'h0, "after abort", g, e);

    // back-to-back at latency 1: one response per cycle
    for (int k = 0; k <= 16; k++) begin
      logic [31:0] ed, a, wd;
      logic ee, w, u;
      logic [1:0] sz;
      @(negedge clk);
      if (k > 0) begin
        check("b2b rvalid", {31'b0, rvalid[0]}, 32'd1);
        check("b2b data", rdata[0], exp_q.pop_front());
        check("b2b err", {31'b0, err[0]}, exp_q.pop_front());
      end
      if (k < 16) begin
        w = 1'($urandom_range(0, 1)); sz = 2'($urandom_range(0, 2)); u = 1'($urandom_range(0, 1));
        a = BASE + $urandom_range(0, 63); wd = $urandom;
        model(0, w, sz, u, a, wd, ed, ee);
        exp_q.push_back(ed);
        exp_q.push_back({31'b0, ee});
        req[0] = 1'b1; we[0] = w; size[0] = sz; uns[0] = u; addr[0] = a; wdata[0] = wd;
      end else begin
        req[0] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    check("b2b drained", {31'b0, rvalid[0]}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Parametrised data memory with a load/store front end for the RISC-V core's LSU, mapped at a configurable base address.
- Supports byte, half-word and word accesses with sign/zero extension and per-byte write enables.
- Uses a request/grant/response handshake with configurable read latency.
- Flags out-of-range, reserved-size and (optionally) misaligned accesses.

Parameters:
BASE_ADDR, 32'h8800_0000, byte address of the first memory location
DEPTH_WORDS, 256, number of 32-bit words (power of 2, 16..4096)
READ_LATENCY, 1, cycles from the accept edge to the read response (1..4)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
req_i  in  1  access request
we_i  in  1  1 = store, 0 = load
size_i  in  2  00 byte, 01 half, 10 word, 11 reserved
unsigned_i  in  1  zero-extend loads (lbu/lhu)
addr_i  in  32  byte address
wdata_i  in  32  store data, right-aligned
gnt_o  out  1  request accepted when req_i & gnt_o at a rising edge
rvalid_o  out  1  one-cycle response strobe
rdata_o  out  32  load result; 0 for stores and errors
err_o  out  1  error flag, valid with rvalid_o

Behaviour:
Reset:
- state IDLE, gnt_o=1, rvalid_o=0, rdata_o=0, err_o=0.
- Memory array is not reset; contents are undefined until written.
- Reset asserted mid-read aborts the read: no rvalid_o is generated.
- A store at the same edge as reset assertion is not performed.

Address decode:
- In range when BASE_ADDR <= addr_i <= BASE_ADDR+4*DEPTH_WORDS-1.
- Word index = (addr_i-BASE_ADDR)>>2; byte lane = addr_i[1:0].

Errors (no write, rdata_o=0, err_o=1 with rvalid_o):
- out of range, including an access whose last byte lies beyond the top address;
- size_i=11.

FSM states: IDLE, WAIT.
- IDLE: gnt_o=1.
  - Accepted store: byte enables are written at the accept edge. rvalid_o=1 in the following cycle with rdata_o=0. State stays IDLE.
  - Accepted load, READ_LATENCY=1: rvalid_o=1 in the following cycle. State stays IDLE.
  - Accepted load, READ_LATENCY>1: go to WAIT, counter=READ_LATENCY-1.
- WAIT: gnt_o=0; counter decrements each edge. At 1, the next edge asserts rvalid_o and returns to IDLE.
- A new request may be accepted in the same cycle rvalid_o is high, giving back-to-back throughput of 1 access per cycle at READ_LATENCY=1.

Load data:
- The addressed word is captured at the accept edge.
- The byte or half-word is selected by the lane and shifted to bit 0.
- The result is sign-extended unless unsigned_i=1; unsigned_i is ignored for word loads.

Store byte enables and lane data:
- byte: 0001<<lane; wdata_i[7:0] replicated to all lanes.
- half: 0011<<lane; wdata_i[15:0] replicated to both halves.
- word: 1111; wdata_i as-is.

Other rules:
- rvalid_o is a single-cycle pulse; err_o and rdata_o hold until the next response.
- req_i while gnt_o=0 is ignored; the requester must hold the request.

Optional Feature:
Macro DMEM_MISALIGN_ERR_EN.
- Defined: a half access with addr_i[0]=1, or a word access with addr_i[1:0]!=0, is an error. No write occurs, rdata_o=0, err_o=1 with rvalid_o, and latency is unchanged.
- Undefined: the address is force-aligned. Half accesses ignore addr_i[0]; word accesses ignore addr_i[1:0]. No error is raised.

Test Plan:
1. Word store and load: sw 0xDEADBEEF @0x8800_0000, then lw @0x8800_0000 -> rdata_o=0xDEADBEEF, err_o=0. rvalid_o arrives exactly READ_LATENCY cycles after the accept edge; repeat for READ_LATENCY=1 and 3.
2. Byte store with extension: sw 0 @0x8800_0004, sb 0x80 @0x8800_0005.
   - lb @0x8800_0005 -> 0xFFFF_FF80.
   - lbu -> 0x0000_0080.
   - lw @0x8800_0004 -> 0x0000_8000.
3. Half store with extension: sh 0xF234 @0x8800_0006.
   - lhu @0x8800_0006 -> 0x0000_F234.
   - lh -> 0xFFFF_F234.
   - lw @0x8800_0004 -> 0xF234_8000.
4. Range and reserved size:
   - lw @0x8800_0400 (DEPTH_WORDS=256) -> err_o=1, rdata_o=0.
   - sw 0x1 @0x87FF_FFFC -> err_o=1, and memory is unchanged.
   - size_i=11 -> err_o=1.
5. Misaligned access: prior sw 0xDEADBEEF @0x8800_0000, then lw @0x8800_0002.
   - With DMEM_MISALIGN_ERR_EN -> err_o=1, rdata_o=0.
   - Without it -> 0xDEADBEEF, err_o=0.
6. Reset mid-read: READ_LATENCY=3, load accepted, rst_i pulsed 1 cycle later -> no rvalid_o, and gnt_o=1 immediately after reset releases. Back-to-back loads at READ_LATENCY=1 then give one response per cycle.
